// File: rtl/bk_status_pkg.sv
// Shared definitions for the BKT status multiplexer: register map, mode
// encodings and configuration reset values.
package bk_status_pkg;

    localparam int NUM_REGS  = 5;
    localparam int OFS_DESR  = 0;
    localparam int OFS_SEL   = 1;
    localparam int OFS_MODE  = 2;
    localparam int OFS_DWELL = 3;

    localparam int DWELL_RST = 1;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_FREEZE = 2'd2
    } mode_e;

    // The unused encoding 3 falls back to STATIC.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_SCAN;
            2'd2:    return MODE_FREEZE;
            default: return MODE_STATIC;
        endcase
    endfunction

endpackage

// File: rtl/bkt_wr_decode.sv
// BKT slave write front end: rising-edge detect on the level write strobe and
// one-hot match of the register index against a contiguous register window.
module bkt_wr_decode #(
    parameter int BASE  = 0,
    parameter int N_REG = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bkt_ready_i,
    input  logic [31:0]      bkt_index_i,
    output logic             wr_pulse,
    output logic [N_REG-1:0] wr_hit
);

    logic z1;
    logic z2;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z1 <= 1'b0;
            z2 <= 1'b0;
        end else begin
            z1 <= bkt_ready_i;
            z2 <= z1;
        end
    end

    // A strobe held high for many cycles still yields a single write.
    assign wr_pulse = z1 & ~z2;

    // NOTE: the output is defaulted before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (wr_pulse && (bkt_index_i == 32'(BASE + i))) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bk_status_mux_n.sv
// N-channel status selector for the BKT readback path: static select, timed
// auto-scan and freeze, with a registered output and a selection-change strobe.
module bk_status_mux_n
    import bk_status_pkg::*;
#(
    parameter int BKP_BASE_INDEX = 500,
    parameter int N_CH           = 4,
    parameter int DW             = 32,
    parameter int DWELL_W        = 16,
    parameter int SEL_W          = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bkt_ready_i,
    input  logic [31:0]        bkt_index_i,
    input  logic [31:0]        bkt_data_i,
    input  logic [N_CH*DW-1:0] bk_status_i,
    output logic [DW-1:0]      bk_status_o,
    output logic               bk_status_vld_o,
    output logic [SEL_W-1:0]   bk_sel_o,
    output logic [3:0]         desr_o
);

    logic                wr_pulse;
    logic [NUM_REGS-1:0] wr_hit;

    // The decoded hit and its data are registered, so configuration lands two
    // edges after bkt_ready_i is first seen high.
    logic [OFS_DWELL:0]  hit_q;
    logic [31:0]         data_q;

    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_n;
    mode_e               mode_q;
    mode_e               mode_n;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DWELL_W-1:0]  dwell_n;

    logic [SEL_W-1:0]    cur_sel_q;
    logic [SEL_W-1:0]    cur_sel_n;
    logic [DWELL_W-1:0]  cnt_q;
    logic [DWELL_W-1:0]  cnt_n;
    logic                started_q;

    bkt_wr_decode #(
        .BASE  (BKP_BASE_INDEX),
        .N_REG (NUM_REGS)
    ) u_wr_decode (
        .clk         (clk),
        .rst         (rst),
        .bkt_ready_i (bkt_ready_i),
        .bkt_index_i (bkt_index_i),
        .wr_pulse    (wr_pulse),
        .wr_hit      (wr_hit)
    );

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return (ch == SEL_W'(N_CH - 1)) ? '0 : ch + SEL_W'(1);
    endfunction

    // Configuration as it stands after any write applied on this edge.
    always_comb begin
        sel_n   = sel_q;
        mode_n  = mode_q;
        dwell_n = dwell_q;
        if (hit_q[OFS_SEL]) begin
            sel_n = (data_q >= 32'(N_CH)) ? '0 : data_q[SEL_W-1:0];
        end
        if (hit_q[OFS_MODE]) begin
            mode_n = decode_mode(data_q[1:0]);
        end
        if (hit_q[OFS_DWELL]) begin
            dwell_n = (data_q[DWELL_W-1:0] == '0) ? DWELL_W'(1) : data_q[DWELL_W-1:0];
        end
    end

    // Channel selection. A SEL write or SCAN entry outranks the terminal count.
    always_comb begin
        cur_sel_n = cur_sel_q;
        cnt_n     = cnt_q;
        case (mode_n)
            MODE_STATIC: begin
                cur_sel_n = sel_n;
                cnt_n     = '0;
            end
            MODE_SCAN: begin
                if ((mode_q != MODE_SCAN) || hit_q[OFS_SEL]) begin
                    cur_sel_n = sel_n;
                    cnt_n     = '0;
                end else if (cnt_q >= (dwell_q - DWELL_W'(1))) begin
                    cur_sel_n = next_ch(cur_sel_q);
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                // FREEZE holds channel and counter.
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q           <= '0;
            data_q          <= '0;
            desr_o          <= '0;
            sel_q           <= '0;
            mode_q          <= MODE_STATIC;
            dwell_q         <= DWELL_W'(DWELL_RST);
            cur_sel_q       <= '0;
            cnt_q           <= '0;
            started_q       <= 1'b0;
            bk_status_vld_o <= 1'b0;
            bk_status_o     <= '0;
        end else begin
            hit_q <= wr_pulse ? wr_hit[OFS_DWELL:0] : '0;
            if (|wr_hit) begin
                data_q <= bkt_data_i;
            end
            if (hit_q[OFS_DESR]) begin
                desr_o <= data_q[3:0];
            end

            sel_q     <= sel_n;
            mode_q    <= mode_n;
            dwell_q   <= dwell_n;
            cur_sel_q <= cur_sel_n;
            cnt_q     <= cnt_n;

            started_q       <= 1'b1;
            bk_status_vld_o <= !started_q || (cur_sel_n != cur_sel_q);

            // Uses the pre-edge mode, so the word seen just before FREEZE is kept.
            if (mode_q != MODE_FREEZE) begin
                bk_status_o <= bk_status_i[int'(cur_sel_q)*DW +: DW];
            end
        end
    end

    assign bk_sel_o = cur_sel_q;

endmodule

// File: tb/tb_bk_status_mux_n.sv
// Scoreboard bench for bk_status_mux_n: the stimulus thread pushes expected
// selection-change events, a negedge monitor pops them on every vld pulse.
module tb_bk_status_mux_n;

    localparam int BASE    = 500;
    localparam int N_CH    = 4;
    localparam int DW      = 8;
    localparam int DWELL_W = 16;
    localparam int SEL_W   = 2;

    logic               clk;
    logic               rst;
    logic               bkt_ready;
    logic [31:0]        bkt_index;
    logic [31:0]        bkt_data;
    logic [N_CH*DW-1:0] status_in;
    logic [DW-1:0]      status_out;
    logic               vld;
    logic [SEL_W-1:0]   sel;
    logic [3:0]         desr;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [DW-1:0]    status;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    bk_status_mux_n #(
        .BKP_BASE_INDEX (BASE),
        .N_CH           (N_CH),
        .DW             (DW),
        .DWELL_W        (DWELL_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bkt_ready_i     (bkt_ready),
        .bkt_index_i     (bkt_index),
        .bkt_data_i      (bkt_data),
        .bk_status_i     (status_in),
        .bk_status_o     (status_out),
        .bk_status_vld_o (vld),
        .bk_sel_o        (sel),
        .desr_o          (desr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Every change event shows the A0+k word of its channel one edge later.
    task automatic push_ev(input int ch);
        ev_t e;
        e.sel    = SEL_W'(ch);
        e.status = DW'(8'hA0 + ch);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns #1 after edge E+1 (E samples ready
    // high), so the register is updated by the following edge.
    task automatic wr(input int idx, input logic [31:0] d);
        bkt_index = 32'(idx);
        bkt_data  = d;
        bkt_ready = 1'b1;
        tick();
        bkt_ready = 1'b0;
        tick();
    endtask

    task automatic set_words(input logic [DW-1:0] base, input bit same);
        for (int k = 0; k < N_CH; k++) begin
            status_in[k*DW +: DW] = same ? base : base + DW'(k);
        end
    endtask

    // Monitor: on each vld pulse pop one event, check the channel now and
    // the status word on the next negedge.
    initial begin
        bit            pend;
        logic [DW-1:0] pend_status;
        ev_t           e;
        pend        = 1'b0;
        pend_status = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("sb_status", 32'(status_out), 32'(pend_status));
                pend = 1'b0;
            end
            if (vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_vld: vld pulsed with sel=%0d, no event expected at %0t",
                             sel, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sel", 32'(sel), 32'(e.sel));
                    pend        = 1'b1;
                    pend_status = e.status;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SEL_W-1:0] hold_tbl [10];
        hold_tbl = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};

        rst       = 1'b1;
        bkt_ready = 1'b0;
        bkt_index = '0;
        bkt_data  = '0;
        set_words(8'hA0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", 32'(status_out), 32'h0);
        check("reset_vld",    32'(vld),        32'h0);
        check("reset_sel",    32'(sel),        32'h0);
        check("reset_desr",   32'(desr),       32'h0);

        // Release: one vld pulse on channel 0.
        push_ev(0);
        rst = 1'b0;
        tick();
        check("first_vld", 32'(vld), 32'h1);
        tick();
        check("first_vld_drop", 32'(vld), 32'h0);

        // SEL = 2: bk_sel_o at E+2, bk_status_o at E+3.
        push_ev(2);
        wr(BASE + 1, 32'd2);
        tick();
        check("sel2_sel_e2",    32'(sel),        32'h2);
        check("sel2_status_e2", 32'(status_out), 32'hA0);
        tick();
        check("sel2_status_e3", 32'(status_out), 32'hA2);
        check("vld_one_cycle",  32'(vld),        32'h0);

        wr(BASE + 0, 32'h5A);
        tick();
        check("desr_write", 32'(desr), 32'hA);

        // Out-of-range SEL stores 0; rewriting 0 must not pulse.
        push_ev(0);
        wr(BASE + 1, 32'd7);
        tick();
        check("sel7_sel", 32'(sel), 32'h0);
        tick();
        check("sel7_status", 32'(status_out), 32'hA0);
        wr(BASE + 1, 32'd0);
        repeat (3) tick();
        check("sel0_again", 32'(sel), 32'h0);

        // Indices outside the register map, the reserved slot and MODE=3.
        wr(BASE + 5, 32'd3);
        wr(BASE + 4, 32'd3);
        wr(BASE - 1, 32'd3);
        wr(BASE + 2, 32'd3);
        repeat (4) tick();
        check("ignored_writes_sel", 32'(sel), 32'h0);

        // SCAN with DWELL = 3.
        wr(BASE + 3, 32'd3);
        push_ev(1); push_ev(2); push_ev(3); push_ev(0);
        wr(BASE + 2, 32'd1);
        for (int k = 0; k < 13; k++) begin
            tick();
            check("scan3_seq", 32'(sel), 32'((k / 3) % 4));
        end

        // FREEZE, then change every input.
        wr(BASE + 2, 32'd2);
        tick();
        check("freeze_sel",    32'(sel),        32'h0);
        check("freeze_status", 32'(status_out), 32'hA0);
        set_words(8'hFF, 1'b1);
        repeat (3) tick();
        check("freeze_hold_status", 32'(status_out), 32'hA0);
        check("freeze_hold_sel",    32'(sel),        32'h0);
        wr(BASE + 2, 32'd0);
        tick();
        check("unfreeze_status_e2", 32'(status_out), 32'hA0);
        tick();
        check("unfreeze_status_e3", 32'(status_out), 32'hFF);
        set_words(8'hA0, 1'b0);
        tick();

        // SCAN with DWELL = 0 behaves as DWELL = 1.
        wr(BASE + 3, 32'd0);
        for (int k = 1; k <= 10; k++) push_ev(k % 4);
        wr(BASE + 2, 32'd1);
        for (int k = 0; k < 9; k++) begin
            tick();
            check("scan1_seq", 32'(sel), 32'(k % 4));
        end
        wr(BASE + 2, 32'd2);
        tick();
        check("scan1_freeze_sel", 32'(sel), 32'h2);

        // Re-enter SCAN from SEL = 2; SEL = 1 lands on the terminal count.
        wr(BASE + 3, 32'd3);
        wr(BASE + 1, 32'd2);
        wr(BASE + 2, 32'd1);
        tick();
        check("scan_entry_sel", 32'(sel), 32'h2);
        push_ev(1); push_ev(2);
        wr(BASE + 1, 32'd1);
        tick();
        check("write_beats_tc", 32'(sel), 32'h1);
        tick();
        check("cnt_restart_1", 32'(sel), 32'h1);
        tick();
        check("cnt_restart_2", 32'(sel), 32'h1);
        tick();
        check("cnt_restart_adv", 32'(sel), 32'h2);

        // Strobe held high for 10 cycles: exactly one SEL = 1 write.
        push_ev(1); push_ev(2); push_ev(3);
        bkt_index = 32'(BASE + 1);
        bkt_data  = 32'd1;
        bkt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("held_ready_seq", 32'(sel), 32'(hold_tbl[k]));
        end
        bkt_ready = 1'b0;
        tick();
        check("held_ready_last", 32'(sel), 32'h3);

        // Reset mid-dwell clears everything without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_status", 32'(status_out), 32'h0);
        check("rst_async_sel",    32'(sel),        32'h0);
        check("rst_async_vld",    32'(vld),        32'h0);
        check("rst_async_desr",   32'(desr),       32'h0);
        repeat (2) @(posedge clk);
        #1;
        push_ev(0);
        rst = 1'b0;
        tick();
        check("rerun_vld", 32'(vld), 32'h1);
        check("rerun_sel", 32'(sel), 32'h0);
        tick();
        check("rerun_status", 32'(status_out), 32'hA0);
        repeat (5) tick();
        check("rerun_static_sel", 32'(sel), 32'h0);

        repeat (2) tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
